// File: rtl/register_file_pkg.sv
// register_file_pkg: shared CPU constants and types for decode, writeback and the register file
package register_file_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] X0 = '0;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: writeback, read-port and debug signals of the register file
// master drives wb_enable/wb_rd/wb_data and the rs1/rs2/dbg indices; slave returns read data and wr_count
interface register_file_if;
  import register_file_pkg::*;
  logic wb_enable;
  idx_t wb_rd;
  word_t wb_data;
  idx_t rs1_addr;
  idx_t rs2_addr;
  idx_t dbg_addr;
  word_t rs1_data;
  word_t rs2_data;
  word_t dbg_data;
  logic [31:0] wr_count;
  modport master (
    output wb_enable, wb_rd, wb_data, rs1_addr, rs2_addr, dbg_addr,
    input rs1_data, rs2_data, dbg_data, wr_count
  );
  modport slave (
    input wb_enable, wb_rd, wb_data, rs1_addr, rs2_addr, dbg_addr,
    output rs1_data, rs2_data, dbg_data, wr_count
  );
endinterface

// File: rtl/register_file_bypass.sv
// regfile_bypass: write-through mux for one read port
// wr_en is the qualified commit strobe; arr_data is the array value at addr; data is the bypassed result
module regfile_bypass
  import register_file_pkg::*;
(
  input  logic  wr_en,
  input  idx_t  wb_rd,
  input  word_t wb_data,
  input  idx_t  addr,
  input  word_t arr_data,
  output word_t data
);
  assign data = (wr_en && wb_rd == addr) ? wb_data : arr_data;
endmodule

// File: rtl/register_file.sv
// register_file: 32 x XLEN flop register file, two bypassed read ports, debug port, write counter
// clk/rst_n plain ports; bus carries writeback, read indices/data, dbg port and wr_count
module register_file
  import register_file_pkg::*;
(
  input logic clk,
  input logic rst_n,
  register_file_if.slave bus
);
  word_t regs [NREG];
  logic [31:0] wr_cnt;
  logic wr_en;
  // rst_n in the strobe also disables bypass while reset is held
  assign wr_en = rst_n && bus.wb_enable && bus.wb_rd != X0;
  // regs[0] is cleared and never written, so x0 reads 0 through the array
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs <= '{default: '0};
      wr_cnt <= '0;
    end else if (wr_en) begin
      regs[bus.wb_rd] <= bus.wb_data;
      wr_cnt <= wr_cnt + 32'd1;
    end
  regfile_bypass u_byp1 (
    .wr_en(wr_en), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
    .addr(bus.rs1_addr), .arr_data(regs[bus.rs1_addr]), .data(bus.rs1_data)
  );
  regfile_bypass u_byp2 (
    .wr_en(wr_en), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
    .addr(bus.rs2_addr), .arr_data(regs[bus.rs2_addr]), .data(bus.rs2_data)
  );
  assign bus.dbg_data = regs[bus.dbg_addr];
  assign bus.wr_count = wr_cnt;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized and directed checks of register_file against an array model
module tb_register_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m [32];
  logic [31:0] cnt;
  register_file_if bus ();
  register_file dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic en, input logic [4:0] rd, input logic [31:0] d);
    return (en && rd != 0 && rd == a) ? d : m[a];
  endfunction
  task automatic drive(input logic en, input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    bus.wb_enable = en;
    bus.wb_rd = rd;
    bus.wb_data = d;
    bus.rs1_addr = a1;
    bus.rs2_addr = a2;
    bus.dbg_addr = ad;
  endtask
  task automatic step(input logic en, input logic [4:0] rd, input logic [31:0] d,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    drive(en, rd, d, a1, a2, ad);
    #1;
    check("rs1", bus.rs1_data, exp_rd(a1, en, rd, d));
    check("rs2", bus.rs2_data, exp_rd(a2, en, rd, d));
    check("dbg", bus.dbg_data, m[ad]);
    check("wr_count", bus.wr_count, cnt);
    @(posedge clk);
    if (en && rd != 0) begin
      m[rd] = d;
      cnt = cnt + 32'd1;
    end
    @(negedge clk);
  endtask
  task automatic clear_model();
    for (int i = 0; i < 32; i++) m[i] = '0;
    cnt = '0;
  endtask
  initial begin
    clear_model();
    drive(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd5, 5'd5);
    #1;
    check("rst_rs1", bus.rs1_data, 32'h0);
    check("rst_rs2", bus.rs2_data, 32'h0);
    check("rst_cnt", bus.wr_count, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_wr_ignored", bus.dbg_data, 32'h0);
    check("rst_cnt_hold", bus.wr_count, 32'h0);
    rst_n = 1'b1;
    step(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0, 5'd7);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
    #1;
    check("x7_rs1", bus.rs1_data, 32'h12345678);
    check("x7_dbg", bus.dbg_data, 32'h12345678);
    check("x7_cnt", bus.wr_count, 32'd1);
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_rs1", bus.rs1_data, 32'h0);
    check("x0_dbg", bus.dbg_data, 32'h0);
    check("x0_cnt", bus.wr_count, 32'd1);
    step(1'b1, 5'd3, 32'h1, 5'd0, 5'd0, 5'd0);
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 5'd3);
    #1;
    check("byp_rs1", bus.rs1_data, 32'hA5A5A5A5);
    check("byp_rs2", bus.rs2_data, 32'hA5A5A5A5);
    check("byp_dbg_old", bus.dbg_data, 32'h1);
    step(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 5'd3);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
    #1;
    check("byp_dbg_new", bus.dbg_data, 32'hA5A5A5A5);
    check("pre_b2b_cnt", bus.wr_count, 32'd3);
    step(1'b1, 5'd9, 32'h1, 5'd9, 5'd9, 5'd9);
    step(1'b1, 5'd9, 32'h2, 5'd9, 5'd9, 5'd9);
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
    #1;
    check("b2b_rs1", bus.rs1_data, 32'h2);
    check("b2b_dbg", bus.dbg_data, 32'h2);
    check("b2b_cnt", bus.wr_count, 32'd5);
    for (int i = 0; i < 400; i++) begin
      logic en;
      logic [4:0] rd, a1, a2, ad;
      en = ($urandom_range(0, 3) != 0);
      rd = 5'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      ad = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      step(en, rd, $urandom, a1, a2, ad);
    end
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
    drive(1'b1, 5'd5, 32'h11111111, 5'd5, 5'd5, 5'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rs1", bus.rs1_data, 32'h0);
    check("mid_rst_rs2", bus.rs2_data, 32'h0);
    check("mid_rst_dbg", bus.dbg_data, 32'h0);
    check("mid_rst_cnt", bus.wr_count, 32'h0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
    force dut.wr_cnt = 32'hFFFFFFFF;
    #1;
    release dut.wr_cnt;
    cnt = 32'hFFFFFFFF;
    step(1'b1, 5'd12, 32'h0BADF00D, 5'd12, 5'd1, 5'd12);
    drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd12, 5'd12);
    #1;
    check("wrap_cnt", bus.wr_count, 32'h0);
    check("wrap_x12", bus.dbg_data, 32'h0BADF00D);
    for (int i = 0; i < 20; i++) step(1'b1, 5'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: XLEN, 32, data width of every register and port.
REQ-002 Parameter: NREG, 32, number of architectural registers (index width 5).
REQ-003 Clock and reset: one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: wb_enable  input  1  write strobe from writeback stage.
REQ-007 Port: wb_rd  input  5  write destination index.
REQ-008 Port: wb_data  input  XLEN  write data.
REQ-009 Port: rs1_addr  input  5  read port 1 index.
REQ-010 Port: rs1_data  output  XLEN  read port 1 data.
REQ-011 Port: rs2_addr  input  5  read port 2 index.
REQ-012 Port: rs2_data  output  XLEN  read port 2 data.
REQ-013 Port: dbg_addr  input  5  debug read index, no bypass.
REQ-014 Port: dbg_data  output  XLEN  debug read data.
REQ-015 Port: wr_count  output  32  count of committed register writes.

Function
REQ-016 Registers x1..x31 SHALL update on the rising clk edge when wb_enable=1 and wb_rd!=0; write is visible in the array from the next cycle.
REQ-017 x0 SHALL always read 0; a write with wb_rd=0 SHALL be discarded and SHALL NOT increment wr_count, even if wb_enable=1.
REQ-018 rs1_data/rs2_data SHALL be combinational (zero-cycle) reads of the array.
REQ-019 Write-through bypass: when wb_enable=1, wb_rd!=0 and wb_rd==rsN_addr, rsN_data SHALL equal wb_data in the same cycle.
REQ-020 Both read ports SHALL bypass independently; rs1_addr==rs2_addr==wb_rd SHALL return wb_data on both.
REQ-021 dbg_data SHALL read the array only (no bypass); dbg_addr=0 returns 0.
REQ-022 wr_count SHALL increment by 1 per committed write (REQ-016), wrap from 0xFFFFFFFF to 0, registered output.
REQ-023 Back-to-back writes to the same index SHALL leave the last value; no write is lost or reordered.
REQ-024 No internal state machine; all state is the register array and wr_count.

Reset
REQ-025 On rst_n=0 all registers x1..x31 SHALL clear to 0 and wr_count to 0 asynchronously, without waiting for clk.
REQ-026 While rst_n=0 writes SHALL be ignored; read ports SHALL return 0 (bypass disabled).
REQ-027 A write coincident with reset deassertion edge SHALL be ignored; first accepted write is on the first clk edge with rst_n=1 sampled high.
REQ-028 Reset asserted mid-operation SHALL discard all prior contents.

Structure
REQ-029 XLEN, NREG, register-index width (5) and the x0 index constant SHALL live in the shared CPU package used by decode and writeback.
REQ-030 Bypass mux SHALL be one sub-module, regfile_bypass, instantiated once per read port.
REQ-031 Array SHALL be flip-flops (not inferred SRAM) to honour asynchronous clear.

Verification
REQ-032 Reset: drive rst_n=0 after writing x5=0xDEADBEEF -> rs1_addr=5 reads 0 immediately, wr_count=0.
REQ-033 Write/read: write x7=0x12345678, next cycle rs1_addr=7 -> 0x12345678, dbg_addr=7 -> 0x12345678, wr_count=1.
REQ-034 x0: wb_enable=1, wb_rd=0, wb_data=0xFFFFFFFF -> rs1_addr=0 reads 0, wr_count unchanged.
REQ-035 Bypass: same cycle wb_rd=3, wb_data=0xA5A5A5A5, rs1_addr=rs2_addr=3 (x3 holds 0x1) -> both ports 0xA5A5A5A5, dbg_addr=3 -> 0x1; next cycle dbg -> 0xA5A5A5A5.
REQ-036 Back-to-back: write x9=1 then x9=2 on consecutive cycles -> x9 reads 2, wr_count advances by 2.
REQ-037 Counter wrap: preload wr_count path to 0xFFFFFFFF via 2^32-1 writes or force, one more write -> wr_count=0.
